// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - command/status bundle for the universal shift register
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int AMT_W = $clog2(WIDTH + 1);

  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amount, d, sin,
    input  q, sout, busy, done
  );

  modport slave (
    input  start, op, amount, d, sin,
    output q, sout, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - WIDTH-bit universal shift register, serial fill enabled by USR_SERIAL_EN
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  univ_shift_reg_if.slave   bus
);
  localparam int AMT_W = $clog2(WIDTH + 1);
  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_SAR   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ROR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [2:0]       op_r, op_n;
  logic [AMT_W-1:0] rem, rem_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic             sout_r, sout_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;

  logic [AMT_W-1:0] amt_sat;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_q;
  logic             step_sout;
  logic             fill;

`ifdef USR_SERIAL_EN
  assign fill = bus.sin;
`else
  // sin stays on the port so instantiations match across builds
  logic unused_sin;
  assign unused_sin = bus.sin;
  assign fill       = 1'b0;
`endif

  assign amt_sat = (bus.amount > AMT_MAX) ? AMT_MAX : bus.amount;

  // One shift/rotate step on the current contents; the command op comes from
  // the port while idle and from the latched copy while sequencing.
  always_comb begin
    step_op   = (state == IDLE) ? bus.op : op_r;
    step_q    = q_r;
    step_sout = sout_r;
    case (step_op)
      OP_SHL: begin
        step_q    = {q_r[WIDTH-2:0], fill};
        step_sout = q_r[WIDTH-1];
      end
      OP_SHR: begin
        step_q    = {fill, q_r[WIDTH-1:1]};
        step_sout = q_r[0];
      end
      OP_SAR: begin
        step_q    = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        step_sout = q_r[0];
      end
      OP_ROL: begin
        step_q    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        step_sout = q_r[WIDTH-1];
      end
      OP_ROR: begin
        step_q    = {q_r[0], q_r[WIDTH-1:1]};
        step_sout = q_r[0];
      end
      default: begin
        step_q    = q_r;
        step_sout = sout_r;
      end
    endcase
  end

  // Next-state logic: accept commands in IDLE, count remaining steps in SHIFT.
  always_comb begin
    state_n = state;
    op_n    = op_r;
    rem_n   = rem;
    q_n     = q_r;
    sout_n  = sout_r;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          op_n = bus.op;
          case (bus.op)
            OP_HOLD: done_n = 1'b1;
            OP_LOAD: begin
              q_n    = bus.d;
              done_n = 1'b1;
            end
            OP_CLEAR: begin
              q_n    = '0;
              sout_n = 1'b0;
              done_n = 1'b1;
            end
            default: begin
              if (amt_sat == '0) begin
                done_n = 1'b1;
              end else begin
                q_n    = step_q;
                sout_n = step_sout;
                if (amt_sat == AMT_ONE) begin
                  done_n = 1'b1;
                end else begin
                  state_n = SHIFT;
                  rem_n   = amt_sat - AMT_ONE;
                end
              end
            end
          endcase
        end
      end
      SHIFT: begin
        q_n    = step_q;
        sout_n = step_sout;
        rem_n  = rem - AMT_ONE;
        if (rem == AMT_ONE) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SHIFT);
  end

  // State and output registers; reset discards any shift in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_r   <= OP_HOLD;
      rem    <= '0;
      q_r    <= '0;
      sout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      op_r   <= op_n;
      rem    <= rem_n;
      q_r    <= q_n;
      sout_r <= sout_n;
      busy_r <= busy_n;
      done_r <= done_n;
    end
  end

  assign bus.q    = q_r;
  assign bus.sout = sout_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register that extends the single-bit reset flip-flop to a WIDTH-bit storage element. It supports parallel load, clear, logical and arithmetic shifts, and rotates. A multi-position shift is sequenced over several clocks under a start/busy/done handshake. It sits in the datapath register layer as the building block for shifter and serial-conversion stages.

## Interface
Parameters:
- WIDTH, 8, data width in bits (≥2).
- AMT_W, $clog2(WIDTH+1), width of the shift-amount port (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock; the block has a single clock domain.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- start  input  1  command strobe; sampled on a rising clk edge only while busy=0.
- op  input  3  command: 000 hold, 001 load, 010 shl, 011 shr (logical), 100 sar (arithmetic), 101 rol, 110 ror, 111 clear.
- amount  input  AMT_W  shift/rotate distance; ignored for hold/load/clear.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial fill bit for shl/shr (see Configuration).
- q  output  WIDTH  register contents.
- sout  output  1  bit displaced by the most recent single-position shift/rotate.
- busy  output  1  multi-cycle shift in progress.
- done  output  1  one-cycle pulse on command completion.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE, start=1 at edge E0: latch op; amount is saturated to WIDTH, producing N.
- hold: q unchanged; done=1 after E0.
- load: q<=d at E0; done=1 after E0.
- clear: q<=0 at E0; sout<=0; done=1 after E0.
- Shift/rotate with N=0: q and sout unchanged; done=1 after E0.
- Shift/rotate with N=1: one step at E0; done=1 after E0; busy stays 0.
- Shift/rotate with N≥2: first step at E0, then go to SHIFT with busy=1 and remaining=N-1.
  - Each edge in SHIFT applies one step and decrements remaining.
  - The edge on which remaining reaches 0 returns to IDLE, deasserts busy and asserts done.
- One step per op:
  - shl: q<={q[W-2:0],fill}, sout=q[W-1].
  - shr: q<={fill,q[W-1:1]}, sout=q[0].
  - sar: MSB replicated, sout=q[0].
  - rol/ror: the wrapped bit moves to the far end, and sout takes that wrapped bit.
- Rotate by N=WIDTH returns the original q. Shift by WIDTH fully replaces q with fill bits.
- start while busy=1 is ignored. op, amount, d, sin and start are don't-care during SHIFT, except that sin is sampled each step.
- reset low at any time: q=0, sout=0, busy=0, done=0, state=IDLE. Remaining steps are discarded, and nothing resumes after reset is released.

## Timing
- Reset values: q=0, sout=0, busy=0, done=0.
- Latency, start edge to done high:
  - 1 cycle for hold/load/clear and for N≤1.
  - N cycles for N≥2, with busy high for N-1 cycles.
- done is a single-cycle pulse that coincides with the first cycle in which busy=0 and a new start is accepted.
- Back-to-back commands: start may be high in the same cycle as done. The new command is accepted, giving throughput of one command per N cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro USR_SERIAL_EN.
  - Defined: fill=sin for shl/shr, so the serial-in/serial-out chain is usable.
  - Undefined: fill=0 and sin is ignored. The port remains present so instantiations are unchanged.
- sar and rotates are unaffected in both builds.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold reset low, then release → q=00, busy=0, done=0. Load A5 → q=A5 and done pulses one cycle after the start edge.
- shl: q=81, shl amount=3, sin=0 → busy high for 2 cycles; q=02, 04, 08 on successive edges; sout ends at 0; done pulses on the 3rd cycle.
- sar versus shr: q=90. sar amount=2 → q=E4. Reload 90, shr amount=2 → q=24.
- Rotate saturation: q=3C, rol amount=8 → q=3C. ror amount=15 (saturated to 8) → q=3C, with 7 busy cycles.
- Reset mid-shift: reset asserted during a shl amount=5 → q=00 and busy=0 immediately. After release, q stays 00 and no done pulse appears.
- USR_SERIAL_EN build: q=00, shr amount=4 with sin=1 → q=F0. Same stimulus without the macro → q=00. start during busy is ignored (check that q is unaffected).
